// File: rtl/riscv_irq_stim_gen.sv
// Interrupt stimulus generator driving the RI5CY irq_i/irq_id_i handshake.
// Optional ack timeout is built when IRQ_GEN_TIMEOUT_EN is defined.
module riscv_irq_stim_gen #(
    parameter int unsigned      N_IRQ_LINES = 32,
    parameter int unsigned      ID_W        = 5,
    parameter int unsigned      GAP_W       = 16,
    parameter int unsigned      LFSR_W      = 32,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(32'hACE1_1234),
    // Galois feedback mask; must give a maximal-length sequence for LFSR_W
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(32'h8020_0003),
    parameter int unsigned      TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [1:0]             mode_i,
    input  logic [GAP_W-1:0]       gap_min_i,
    input  logic [GAP_W-1:0]       gap_max_i,
    input  logic [N_IRQ_LINES-1:0] id_mask_i,
    input  logic [ID_W-1:0]        dir_id_i,
    input  logic                   dir_start_i,
    output logic                   irq_o,
    output logic [ID_W-1:0]        irq_id_o,
    input  logic                   irq_ack_i,
    input  logic [ID_W-1:0]        irq_ack_id_i,
    output logic                   busy_o,
    output logic [31:0]            irq_count_o,
    output logic                   ack_err_o,
    output logic                   timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_PICK, S_ASSERT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic              r_dir;
    logic              w_dir_nxt;
    logic              r_irq;
    logic              w_irq_nxt;
    logic [ID_W-1:0]   r_irq_id;
    logic [ID_W-1:0]   w_irq_id_nxt;
    logic              r_busy;
    logic [31:0]       r_cnt;
    logic [31:0]       w_cnt_nxt;
    logic              r_ack_err;
    logic              w_ack_err_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic              w_done;

    logic              w_rnd_run;
    logic              w_dir_run;
    logic              w_ack_match;
    logic [GAP_W-1:0]  w_gap_val;
    logic [ID_W-1:0]   w_li;
    logic              w_lo_found;
    logic              w_hi_found;
    logic [ID_W-1:0]   w_lo_id;
    logic [ID_W-1:0]   w_hi_id;
    logic [ID_W-1:0]   w_pick_id;

    // Gap in [min, max(max,min)]: mask LFSR bits to the span, fold overshoot back once
    function automatic logic [GAP_W-1:0] f_gap(input logic [GAP_W-1:0] mn,
                                               input logic [GAP_W-1:0] mx,
                                               input logic [GAP_W-1:0] lg);
        logic [GAP_W-1:0] eff;
        logic [GAP_W-1:0] span;
        logic [GAP_W-1:0] m;
        logic [GAP_W-1:0] o;
        eff  = (mx > mn) ? mx : mn;
        span = eff - mn;
        m    = span;
        for (int s = 1; s < int'(GAP_W); s = s * 2) begin
            m = m | (m >> s);
        end
        o = lg & m;
        if (o > span) begin
            o = o - (span + GAP_W'(1));
        end
        return mn + o;
    endfunction

    assign w_rnd_run   = (mode_i == 2'b01) && enable_i;
    assign w_dir_run   = (mode_i == 2'b10);
    assign w_ack_match = irq_ack_i && (irq_ack_id_i == r_irq_id);
    assign w_gap_val   = f_gap(gap_min_i, gap_max_i, r_lfsr[GAP_W-1:0]);
    assign w_li        = r_lfsr[GAP_W+ID_W-1:GAP_W];

    // Rotating search from w_li: lowest enabled ID >= start, else lowest enabled overall
    always_comb begin
        w_lo_found = 1'b0;
        w_hi_found = 1'b0;
        w_lo_id    = '0;
        w_hi_id    = '0;
        for (int i = int'(N_IRQ_LINES) - 1; i >= 0; i--) begin
            if (id_mask_i[i]) begin
                w_lo_found = 1'b1;
                w_lo_id    = ID_W'(i);
                if (i >= int'(w_li)) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = ID_W'(i);
                end
            end
        end
    end

    assign w_pick_id = w_hi_found ? w_hi_id : w_lo_id;

`ifdef IRQ_GEN_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != S_ASSERT)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic w_to_hit;
    logic w_unused_timeout;
    assign w_to_hit         = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_nxt     = r_gap_cnt;
        w_dir_nxt     = r_dir;
        w_irq_nxt     = r_irq;
        w_irq_id_nxt  = r_irq_id;
        w_cnt_nxt     = r_cnt;
        w_ack_err_nxt = r_ack_err;
        w_timeout_nxt = r_timeout;
        w_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rnd_run) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = w_gap_val;
                    w_dir_nxt   = 1'b0;
                end else if (w_dir_run && dir_start_i) begin
                    w_state_nxt = S_PICK;
                    w_dir_nxt   = 1'b1;
                end
            end
            S_GAP: begin
                if (!w_rnd_run) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt = S_PICK;
                end else begin
                    w_gap_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            S_PICK: begin
                if (r_dir) begin
                    if (!w_dir_run) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt  = S_ASSERT;
                        w_irq_nxt    = 1'b1;
                        w_irq_id_nxt = dir_id_i;
                    end
                end else if (!w_rnd_run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_lo_found) begin
                    w_state_nxt  = S_ASSERT;
                    w_irq_nxt    = 1'b1;
                    w_irq_id_nxt = w_pick_id;
                end else begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = w_gap_val;
                end
            end
            S_ASSERT: begin
                if (w_ack_match) begin
                    w_done    = 1'b1;
                    w_cnt_nxt = r_cnt + 32'd1;
                end else if (w_to_hit) begin
                    w_done        = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
                if (w_done) begin
                    w_irq_nxt = 1'b0;
                    if (w_rnd_run) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = w_gap_val;
                        w_dir_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (irq_ack_i && !((r_state == S_ASSERT) && (irq_ack_id_i == r_irq_id))) begin
            w_ack_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr    <= LFSR_SEED;
            r_gap_cnt <= '0;
            r_dir     <= 1'b0;
            r_irq     <= 1'b0;
            r_irq_id  <= '0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_lfsr    <= {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
            r_gap_cnt <= w_gap_nxt;
            r_dir     <= w_dir_nxt;
            r_irq     <= w_irq_nxt;
            r_irq_id  <= w_irq_id_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_cnt     <= w_cnt_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign irq_o       = r_irq;
    assign irq_id_o    = r_irq_id;
    assign busy_o      = r_busy;
    assign irq_count_o = r_cnt;
    assign ack_err_o   = r_ack_err;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_riscv_irq_stim_gen.sv
// Directed bench for riscv_irq_stim_gen: vector table plus multi-cycle handshake sequences.
module tb_riscv_irq_stim_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] gap_min;
    logic [15:0] gap_max;
    logic [31:0] id_mask;
    logic [4:0]  dir_id;
    logic        dir_start;
    logic        irq;
    logic [4:0]  irq_id;
    logic        ack;
    logic [4:0]  ack_id;
    logic        busy;
    logic [31:0] cnt;
    logic        ack_err;
    logic        tmo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_irq_stim_gen #(.TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
        .gap_min_i(gap_min), .gap_max_i(gap_max), .id_mask_i(id_mask),
        .dir_id_i(dir_id), .dir_start_i(dir_start),
        .irq_o(irq), .irq_id_o(irq_id), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
        .busy_o(busy), .irq_count_o(cnt), .ack_err_o(ack_err), .timeout_o(tmo)
    );

    typedef struct {
        logic [1:0]  mode;
        logic        en;
        logic        ds;
        logic [4:0]  did;
        logic        ack;
        logic [4:0]  aid;
        logic        e_irq;
        logic [4:0]  e_id;
        logic        e_busy;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];
    int   exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'b00; dir_start = 1'b0; ack = 1'b0; ack_id = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // num random handshakes; request latency in edges (enable/ack edge = 1) must lie in [lo,hi]
    task automatic run_hs(input int num, input int lo, input int hi);
        int n;
        mode = 2'b01; enable = 1'b1;
        tick();
        n = 1;
        for (int h = 0; h < num; h++) begin
            while (!irq && n < 64) begin
                tick();
                n++;
            end
            checks++;
            if (!irq || n < lo || n > hi) begin
                failures++;
                $display("FAIL hs_latency hs=%0d actual=%0d expected=[%0d,%0d] irq=%0b", h, n, lo, hi, irq);
            end
            chk("hs_id_in_mask", 32'(id_mask[irq_id]), 32'd1);
            ack = 1'b1; ack_id = irq_id;
            if (h == num - 1) enable = 1'b0;
            tick();
            ack = 1'b0;
            exp_cnt++;
            chk("hs_irq_drop", 32'(irq), 32'd0);
            n = 1;
        end
        chk("hs_count", cnt, 32'(exp_cnt));
    endtask

    initial begin
        int  n;
        logic seen;
        gap_min = 16'd4; gap_max = 16'd4; id_mask = 32'h0000_0100; dir_id = '0;
        do_reset();
        chk("rst_irq", 32'(irq), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_err", 32'(ack_err), 0);
        chk("rst_tmo", 32'(tmo), 0);

        vt[0]  = '{2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 32'd0, 1'b0};
        vt[1]  = '{2'd2, 1'b0, 1'b1, 5'd11, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 32'd0, 1'b0};
        vt[2]  = '{2'd2, 1'b0, 1'b0, 5'd11, 1'b0, 5'd0,  1'b1, 5'd11, 1'b1, 32'd0, 1'b0};
        vt[3]  = '{2'd2, 1'b0, 1'b0, 5'd11, 1'b0, 5'd0,  1'b1, 5'd11, 1'b1, 32'd0, 1'b0};
        vt[4]  = '{2'd2, 1'b0, 1'b0, 5'd11, 1'b1, 5'd11, 1'b0, 5'd11, 1'b0, 32'd1, 1'b0};
        vt[5]  = '{2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd11, 1'b0, 32'd1, 1'b0};
        for (int i = 6; i <= 11; i++)
            vt[i] = '{2'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 32'd1, 1'b0};
        vt[12] = '{2'd1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 32'd1, 1'b0};
        vt[13] = '{2'd1, 1'b1, 1'b0, 5'd0,  1'b1, 5'd3,  1'b1, 5'd8,  1'b1, 32'd1, 1'b1};
        vt[14] = '{2'd1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd8,  1'b0, 5'd8,  1'b0, 32'd2, 1'b1};
        vt[15] = '{2'd1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd8,  1'b1, 32'd2, 1'b1};
        vt[16] = '{2'd1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd8,  1'b0, 32'd2, 1'b1};
        vt[17] = '{2'd3, 1'b1, 1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 5'd8,  1'b0, 32'd2, 1'b1};
        vt[18] = '{2'd0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd8,  1'b0, 32'd2, 1'b1};
        vt[19] = '{2'd2, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0,  1'b0, 5'd8,  1'b1, 32'd2, 1'b1};
        vt[20] = '{2'd0, 1'b0, 1'b0, 5'd31, 1'b0, 5'd0,  1'b0, 5'd8,  1'b0, 32'd2, 1'b1};

        for (int i = 0; i < NV; i++) begin
            mode = vt[i].mode; enable = vt[i].en; dir_start = vt[i].ds; dir_id = vt[i].did;
            ack = vt[i].ack; ack_id = vt[i].aid;
            tick();
            checks++;
            if (irq !== vt[i].e_irq || irq_id !== vt[i].e_id || busy !== vt[i].e_busy ||
                cnt !== vt[i].e_cnt || ack_err !== vt[i].e_err) begin
                failures++;
                $display("FAIL vec%0d actual irq=%0b id=%0d busy=%0b cnt=%0d err=%0b expected irq=%0b id=%0d busy=%0b cnt=%0d err=%0b",
                         i, irq, irq_id, busy, cnt, ack_err,
                         vt[i].e_irq, vt[i].e_id, vt[i].e_busy, vt[i].e_cnt, vt[i].e_err);
            end
        end
        ack = 1'b0; dir_start = 1'b0;

        // Random mode: fixed gap 4, 100 handshakes, all ID 8
        do_reset();
        exp_cnt = 0;
        gap_min = 16'd4; gap_max = 16'd4; id_mask = 32'h0000_0100;
        run_hs(100, 7, 7);
        chk("hs100_count", cnt, 32'd100);
        chk("hs100_no_err", 32'(ack_err), 0);

        // gap_max below gap_min collapses to gap_min; wrap-around IDs 0/31
        gap_min = 16'd3; gap_max = 16'd1; id_mask = 32'h8000_0001;
        run_hs(5, 6, 6);
        // Non-power-of-two span
        gap_min = 16'd2; gap_max = 16'd9; id_mask = 32'hFFFF_FFFF;
        run_hs(20, 5, 12);
        gap_min = 16'd0; gap_max = 16'd0; id_mask = 32'h0000_0400;
        run_hs(3, 3, 3);

        // Reset held during ASSERT
        mode = 2'b10; dir_id = 5'd7; dir_start = 1'b1;
        tick();
        dir_start = 1'b0;
        tick();
        chk("pre_rst_irq", 32'(irq), 1);
        chk("pre_rst_id", 32'(irq_id), 7);
        rst = 1'b1;
        tick();
        chk("rst_mid_irq", 32'(irq), 0);
        chk("rst_mid_cnt", cnt, 0);
        tick(); tick();
        rst = 1'b0; mode = 2'b00;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        // Directed single shot, ack four edges later
        mode = 2'b10; dir_id = 5'd11; dir_start = 1'b1;
        tick();
        dir_start = 1'b0;
        chk("dir_pick_irq", 32'(irq), 0);
        tick();
        chk("dir_irq", 32'(irq), 1);
        chk("dir_id", 32'(irq_id), 11);
        repeat (3) tick();
        chk("dir_hold", 32'(irq), 1);
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        chk("dir_ack_irq", 32'(irq), 0);
        chk("dir_ack_cnt", cnt, 1);
        chk("dir_ack_err", 32'(ack_err), 0);

        // Stray ack in IDLE
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        chk("stray_err", 32'(ack_err), 1);
        chk("stray_cnt", cnt, 1);

        // Empty mask: never requests, stays busy
        do_reset();
        gap_min = 16'd0; gap_max = 16'd0; id_mask = 32'h0;
        mode = 2'b01; enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (irq) seen = 1'b1;
        end
        chk("mask0_no_irq", 32'(seen), 0);
        chk("mask0_busy", 32'(busy), 1);
        enable = 1'b0;
        tick();
        chk("mask0_abort", 32'(busy), 0);

`ifdef IRQ_GEN_TIMEOUT_EN
        do_reset();
        mode = 2'b10; dir_id = 5'd5; dir_start = 1'b1;
        tick();
        dir_start = 1'b0;
        tick();
        chk("to_irq_rise", 32'(irq), 1);
        n = 0;
        while (irq && n < 100) begin
            tick();
            n++;
        end
        chk("to_len", 32'(n), 16);
        chk("to_flag", 32'(tmo), 1);
        chk("to_cnt", cnt, 0);
        chk("to_busy", 32'(busy), 0);
`else
        n = 0;
        chk("no_to_flag", 32'(tmo), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
